// File: rtl/onehot_pkg.sv
`default_nettype none
// ============================================================================
// Module : onehot_pkg
// Brief  : Shared encode-mode enum for the one-hot stream encoder.
// Rev    : 1.0
// ============================================================================
package onehot_pkg;

    typedef enum logic [1:0] {
        ENC_STRICT   = 2'd0,
        ENC_PRIO_LSB = 2'd1,
        ENC_PRIO_MSB = 2'd2
    } encode_mode_e;

endpackage
`default_nettype wire

// File: rtl/stream_stage_reg.sv
`default_nettype none
// ============================================================================
// Module : stream_stage_reg
// Brief  : One elastic valid/ready register stage with synchronous flush.
// Rev    : 1.0
// ============================================================================
module stream_stage_reg #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic valid_i,
    output logic ready_o,
    input  T     data_i,
    output logic valid_o,
    input  logic ready_i,
    output T     data_o
);

    logic valid_q;
    T     data_q;

    // Accept when empty or when the held beat leaves this same cycle.
    assign ready_o = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (flush_i) begin
                valid_q <= 1'b0;
            end else if (ready_o) begin
                valid_q <= valid_i;
            end
            if (valid_i && ready_o && !flush_i) begin
                data_q <= data_i;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/onehot_to_bin_stream.sv
`default_nettype none
// ============================================================================
// Module : onehot_to_bin_stream
// Brief  : Streaming one-hot/priority-to-binary encoder, 1-2 elastic stages.
// Rev    : 1.0
// ============================================================================
module onehot_to_bin_stream
    import onehot_pkg::*;
#(
    parameter int unsigned  ONEHOT_WIDTH  = 16,
    parameter int unsigned  BIN_WIDTH     = (ONEHOT_WIDTH == 1) ? 1 : $clog2(ONEHOT_WIDTH),
    parameter encode_mode_e MODE          = ENC_STRICT,
    parameter int unsigned  PIPE_REGS     = 1,
    parameter int unsigned  ERR_CNT_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [ONEHOT_WIDTH-1:0]  onehot_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [BIN_WIDTH-1:0]     bin_o,
    output logic                     zero_o,
    output logic                     multi_o,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
    input  logic                     err_cnt_clr_i
);

    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

    typedef struct packed {
        logic [BIN_WIDTH-1:0] bin;
        logic                 zero;
        logic                 multi;
    } enc_t;

    typedef struct packed {
        logic [ONEHOT_WIDTH-1:0] vec;
        logic                    zero;
        logic                    multi;
    } iso_t;

    function automatic logic [ONEHOT_WIDTH-1:0] reverse(input logic [ONEHOT_WIDTH-1:0] x);
        logic [ONEHOT_WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < ONEHOT_WIDTH; i++) begin
            r[i] = x[ONEHOT_WIDTH-1-i];
        end
        return r;
    endfunction

    // Reduce the vector to the single bit the mode selects; STRICT keeps it raw.
    function automatic logic [ONEHOT_WIDTH-1:0] isolate(input logic [ONEHOT_WIDTH-1:0] x);
        logic [ONEHOT_WIDTH-1:0] rv;
        rv = reverse(x);
        case (MODE)
            ENC_PRIO_LSB: return x & (~x + ONEHOT_WIDTH'(1));
            ENC_PRIO_MSB: return reverse(rv & (~rv + ONEHOT_WIDTH'(1)));
            default:      return x;
        endcase
    endfunction

    function automatic logic [BIN_WIDTH-1:0] or_index(input logic [ONEHOT_WIDTH-1:0] x);
        logic [BIN_WIDTH-1:0] b;
        b = '0;
        for (int unsigned i = 0; i < ONEHOT_WIDTH; i++) begin
            if (x[i]) begin
                b = b | BIN_WIDTH'(i);
            end
        end
        return b;
    endfunction

    logic [ONEHOT_WIDTH-1:0] iso_vec;
    logic                    in_zero;
    logic                    in_multi;
    enc_t                    enc_out;

    assign iso_vec  = isolate(onehot_i);
    assign in_zero  = ~|onehot_i;
    assign in_multi = |(onehot_i & (onehot_i - ONEHOT_WIDTH'(1)));

    generate
        if (PIPE_REGS == 1) begin : g_pipe1
            enc_t enc_in;
            assign enc_in = '{bin: or_index(iso_vec), zero: in_zero, multi: in_multi};

            stream_stage_reg #(.T(enc_t)) u_stage0 (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .flush_i (flush_i),
                .valid_i (valid_i),
                .ready_o (ready_o),
                .data_i  (enc_in),
                .valid_o (valid_o),
                .ready_i (ready_i),
                .data_o  (enc_out)
            );
        end else if (PIPE_REGS == 2) begin : g_pipe2
            iso_t iso_in;
            iso_t iso_q;
            enc_t enc_mid;
            logic mid_valid;
            logic mid_ready;

            assign iso_in  = '{vec: iso_vec, zero: in_zero, multi: in_multi};
            assign enc_mid = '{bin: or_index(iso_q.vec), zero: iso_q.zero, multi: iso_q.multi};

            stream_stage_reg #(.T(iso_t)) u_stage0 (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .flush_i (flush_i),
                .valid_i (valid_i),
                .ready_o (ready_o),
                .data_i  (iso_in),
                .valid_o (mid_valid),
                .ready_i (mid_ready),
                .data_o  (iso_q)
            );

            stream_stage_reg #(.T(enc_t)) u_stage1 (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .flush_i (flush_i),
                .valid_i (mid_valid),
                .ready_o (mid_ready),
                .data_i  (enc_mid),
                .valid_o (valid_o),
                .ready_i (ready_i),
                .data_o  (enc_out)
            );
        end else begin : g_bad_pipe
            $fatal(1, "onehot_to_bin_stream: PIPE_REGS must be 1 or 2");
            assign ready_o = 1'b0;
            assign valid_o = 1'b0;
            assign enc_out = '0;
        end
    endgenerate

    assign bin_o   = enc_out.bin;
    assign zero_o  = enc_out.zero;
    assign multi_o = enc_out.multi;

    logic count_err;
    assign count_err = (MODE == ENC_STRICT) && valid_o && ready_i && multi_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_o <= '0;
        end else if (err_cnt_clr_i) begin
            err_cnt_o <= '0;
        end else if (count_err && (err_cnt_o != ERR_MAX)) begin
            err_cnt_o <= err_cnt_o + ERR_CNT_WIDTH'(1);
        end
    end

`ifndef COMMON_CELLS_ASSERTS_OFF
    a_valid_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_i && !ready_o && !flush_i) |=> valid_i);
    a_data_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_i && !ready_o && !flush_i) |=> $stable(onehot_i));
`endif

endmodule
`default_nettype wire
